// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the two-port multiplier arbiter.
// Optional stats counters are enabled with MULT_ARB_STATS_EN.
package mult_arb_pkg;

  localparam int WIDTH = 16;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Request ports and tagged response channel of the multiplier arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface mult_arbiter_if #(
  parameter int WIDTH = mult_arb_pkg::WIDTH
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_result;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );
endinterface

// File: rtl/mult8bit.sv
// 16x16->32 unsigned combinational multiplier
// built from four 8x8 partial products.
module mult8bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] ll, lh, hl, hh;

  assign ll = {8'd0, a[7:0]}  * {8'd0, b[7:0]};
  assign lh = {8'd0, a[7:0]}  * {8'd0, b[15:8]};
  assign hl = {8'd0, a[15:8]} * {8'd0, b[7:0]};
  assign hh = {8'd0, a[15:8]} * {8'd0, b[15:8]};

  assign p = {hh, ll}
           + {8'd0, lh, 8'd0}
           + {8'd0, hl, 8'd0};
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one registered multiplier between two ports.
// `define MULT_ARB_STATS_EN adds grant_cnt0/grant_cnt1 outputs.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = mult_arb_pkg::WIDTH
) (
  input  logic clk,
  input  logic rst,
  mult_arbiter_if.slave bus
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  logic [1:0]         state;
  logic               last_grant;
  logic               grant0;
  logic               grant1;
  op_t                op_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] res_q;
  logic               valid_q;
  logic               id_q;

  // last_grant resets to REQ1 so port 0 wins first contention
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        bus.req0_valid && bus.req1_valid: begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end
        bus.req0_valid && !bus.req1_valid:
          grant0 = 1'b1;
        !bus.req0_valid && bus.req1_valid:
          grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  mult8bit u_mult (
    .a (op_q.a),
    .b (op_q.b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ1;
      op_q       <= '0;
      valid_q    <= 1'b0;
      id_q       <= REQ0;
      res_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_q <= grant1
                  ? {REQ1, bus.req1_a, bus.req1_b}
                  : {REQ0, bus.req0_a, bus.req0_b};
            last_grant <= grant1;
            state      <= COMPUTE;
          end
        end
        COMPUTE: begin
          res_q   <= prod;
          id_q    <= op_q.id;
          valid_q <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;

`ifdef MULT_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant0) cnt0_q <= cnt0_q + 16'd1;
      if (grant1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = rst ? 16'd0 : cnt0_q;
  assign grant_cnt1 = rst ? 16'd0 : cnt1_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: accepts push, responses pop.
// Build with +define+MULT_ARB_STATS_EN to cover the grant counters.
module tb_mult_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] res;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expq[$];
  bit   gq[$];
  logic [31:0] exp0;
  logic [31:0] exp1;
  int checks = 0;
  int errors = 0;

  mult_arbiter_if #(.WIDTH(16)) bus ();

`ifdef MULT_ARB_STATS_EN
  logic [15:0] gc0, gc1;
`endif

  mult_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MULT_ARB_STATS_EN
    ,
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(
    input string       n,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, exp);
    end
  endfunction

  // acceptance side: push expected response
  always @(negedge clk) begin
    if (!rst) begin
      chk("both_ready",
          {63'd0, bus.req0_ready & bus.req1_ready}, 0);
      if (bus.req0_valid && bus.req0_ready) begin
        expq.push_back('{1'b0, exp0});
        gq.push_back(1'b0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        expq.push_back('{1'b1, exp1});
        gq.push_back(1'b1);
      end
    end
  end

  // response side: pop and compare
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d res %0h",
                 bus.rsp_id, bus.rsp_result);
      end else begin
        e = expq.pop_front();
        chk("rsp_id", {63'd0, bus.rsp_id}, {63'd0, e.id});
        chk("rsp_result", {32'd0, bus.rsp_result},
            {32'd0, e.res});
      end
    end
  end

  task automatic issue(
    input bit          p,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [31:0] e
  );
    int n;
    @(posedge clk); #1;
    if (p) begin
      bus.req1_a = a; bus.req1_b = b;
      exp1 = e; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b;
      exp0 = e; bus.req0_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(p ? bus.req1_ready : bus.req0_ready)
           && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("issue_timeout", {63'd0, n >= 50}, 0);
    @(posedge clk); #1;
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", expq.size(), 0);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", {63'd0, bus.rsp_valid}, 1);
  endtask

  // both ports valid; grants must alternate starting at port 0
  task automatic contend(input int cnt);
    int n;
    gq.delete();
    @(posedge clk); #1;
    bus.req0_a = 16'd1;   bus.req0_b = 16'hFFFF;
    exp0 = 32'd65535;
    bus.req1_a = 16'd255; bus.req1_b = 16'd2;
    exp1 = 32'd510;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    n = 0;
    while (gq.size() < cnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
    chk("grant_count", gq.size(), cnt);
    for (int i = 0; i < gq.size() && i < cnt; i++)
      chk($sformatf("grant_order%0d", i),
          {63'd0, gq[i]}, i % 2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_a = '0; bus.req1_b = '0;
    exp0 = '0; exp1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, bus.rsp_valid}, 0);
    chk("rst_id", {63'd0, bus.rsp_id}, 0);
    chk("rst_result", {32'd0, bus.rsp_result}, 0);
    rst = 1'b0;

    // single request, latency
    @(posedge clk); #1;
    bus.req0_a = 16'd1; bus.req0_b = 16'd2;
    exp0 = 32'd2; bus.req0_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready0", {63'd0, bus.req0_ready}, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_ready0_low", {63'd0, bus.req0_ready}, 0);
    chk("t1_valid_early", {63'd0, bus.rsp_valid}, 0);
    @(negedge clk);
    chk("t1_valid_lat", {63'd0, bus.rsp_valid}, 1);
    drain();

    // full range
    issue(1'b1, 16'd255, 16'hFFFF, 32'd16711425);
    drain();
    issue(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    drain();

    contend(4);

    // back-pressure with req1 pending
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'd3, 16'd5, 32'd15);
    @(posedge clk); #1;
    bus.req1_a = 16'd7; bus.req1_b = 16'd9;
    exp1 = 32'd63; bus.req1_valid = 1'b1;
    wait_rsp();
    repeat (5) begin
      chk("bp_valid", {63'd0, bus.rsp_valid}, 1);
      chk("bp_id", {63'd0, bus.rsp_id}, 0);
      chk("bp_result", {32'd0, bus.rsp_result}, 15);
      chk("bp_ready0", {63'd0, bus.req0_ready}, 0);
      chk("bp_ready1", {63'd0, bus.req1_ready}, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready1", {63'd0, bus.req1_ready}, 0);
    @(negedge clk);
    chk("bp_next_ready1", {63'd0, bus.req1_ready}, 1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drain();

    // reset while in COMPUTE
    issue(1'b0, 16'd2, 16'd3, 32'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstc_valid", {63'd0, bus.rsp_valid}, 0);
    expq.delete();
    contend(2);

    // reset while in RESP
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'd4, 16'd4, 32'd16);
    wait_rsp();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstr_valid", {63'd0, bus.rsp_valid}, 0);
    expq.delete();
    bus.rsp_ready = 1'b1;
    contend(2);

`ifdef MULT_ARB_STATS_EN
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("cnt0_in_rst", {48'd0, gc0}, 0);
    chk("cnt1_in_rst", {48'd0, gc1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 16'd2, 16'd2, 32'd4);
      drain();
    end
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 16'd3, 16'd3, 32'd9);
      drain();
    end
    chk("cnt0", {48'd0, gc0}, 3);
    chk("cnt1", {48'd0, gc1}, 2);
    @(posedge clk); #1;
    force dut.cnt0_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt0_q;
    issue(1'b0, 16'd2, 16'd2, 32'd4);
    drain();
    chk("cnt0_wrap", {48'd0, gc0}, 0);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
